// File: rtl/axis_loopback_pkg.sv
// rtl/axis_loopback_pkg.sv - shared widths, entry layout and packet-gate states for axis_loopback_fifo
package axis_loopback_pkg;

  typedef enum logic {
    IDLE_GATE = 1'b0,
    RELEASE   = 1'b1
  } pm_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Entry layout, LSB first: tdest, tid, tlast, tstrb, tkeep, tdata
  function automatic int off_last(input int id_w, input int dest_w);
    return id_w + dest_w;
  endfunction

  function automatic int off_strb(input int id_w, input int dest_w);
    return off_last(id_w, dest_w) + 1;
  endfunction

  function automatic int off_keep(input int data_w, input int id_w, input int dest_w);
    return off_strb(id_w, dest_w) + data_w / 8;
  endfunction

  function automatic int off_data(input int data_w, input int id_w, input int dest_w);
    return off_keep(data_w, id_w, dest_w) + data_w / 8;
  endfunction

  function automatic int entry_w(input int data_w, input int id_w, input int dest_w);
    return off_data(data_w, id_w, dest_w) + data_w;
  endfunction

endpackage

// File: rtl/axis_sdp_ram.sv
// rtl/axis_sdp_ram.sv - simple dual-port RAM with one-cycle registered read
module axis_sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // The read register doubles as the stream output stage, so it is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst)          rd_data_o <= '0;
    else if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/axis_loopback_fifo.sv
// rtl/axis_loopback_fifo.sv - AXI4-Stream loopback buffer with optional packet gating and ID swap
module axis_loopback_fifo
  import axis_loopback_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int ID_W        = 4,
  parameter int DEST_W      = 4,
  parameter int PACKET_MODE = 0,
  parameter int SWAP_ID     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [DATA_W-1:0]           s_axis_tdata,
  input  logic [DATA_W/8-1:0]         s_axis_tkeep,
  input  logic [DATA_W/8-1:0]         s_axis_tstrb,
  input  logic                        s_axis_tlast,
  input  logic [ID_W-1:0]             s_axis_tid,
  input  logic [DEST_W-1:0]           s_axis_tdest,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic [DATA_W/8-1:0]         m_axis_tkeep,
  output logic [DATA_W/8-1:0]         m_axis_tstrb,
  output logic                        m_axis_tlast,
  output logic [ID_W-1:0]             m_axis_tid,
  output logic [DEST_W-1:0]           m_axis_tdest,
  output logic [clog2(DEPTH+1)-1:0]   data_count,
  output logic [clog2(DEPTH+1)-1:0]   pkt_count,
  output logic                        oversize,
  input  logic                        clr_stats
);

  localparam int AW       = clog2(DEPTH);
  localparam int CW       = clog2(DEPTH + 1);
  localparam int KW       = DATA_W / 8;
  localparam int EW       = entry_w(DATA_W, ID_W, DEST_W);
  localparam int OFF_LAST = off_last(ID_W, DEST_W);
  localparam int OFF_STRB = off_strb(ID_W, DEST_W);
  localparam int OFF_KEEP = off_keep(DATA_W, ID_W, DEST_W);
  localparam int OFF_DATA = off_data(DATA_W, ID_W, DEST_W);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d, pkt_q, pkt_d;
  logic          tready_q, valid_q, valid_d, oversize_q, oversize_d;
  pm_state_e     state_q, state_d;
  logic          wr, rd, load, ram_has, pkt_in_ram, gate_open, out_last;
  logic [EW-1:0] wr_entry, rd_entry;

  assign wr_entry = {s_axis_tdata, s_axis_tkeep, s_axis_tstrb, s_axis_tlast, s_axis_tid, s_axis_tdest};
  assign out_last = rd_entry[OFF_LAST];

  assign wr      = s_axis_tvalid & tready_q;
  assign rd      = valid_q & m_axis_tready;
  // cnt_q includes the output stage, so the RAM holds cnt_q - valid_q beats.
  assign ram_has = cnt_q != CW'(valid_q);
  // A packet whose tlast already sits in the output stage does not open the gate for the next one.
  assign pkt_in_ram = pkt_q != CW'(valid_q & out_last);
  assign gate_open  = (PACKET_MODE == 0) | pkt_in_ram |
                      ((state_q == RELEASE) & ~(valid_q & out_last));
  assign load       = (~valid_q | rd) & ram_has & gate_open;

  assign cnt_d   = cnt_q + CW'(wr) - CW'(rd);
  assign pkt_d   = pkt_q + CW'(wr & s_axis_tlast) - CW'(rd & out_last);
  assign valid_d = load | (valid_q & ~rd);
  assign wptr_d  = wptr_q + AW'(wr);
  assign rptr_d  = rptr_q + AW'(load);

  always_comb begin
    state_d    = state_q;
    oversize_d = oversize_q;
    if (clr_stats) oversize_d = 1'b0;
    case (state_q)
      IDLE_GATE: begin
        if ((PACKET_MODE != 0) && (cnt_q == CW'(DEPTH)) && (pkt_q == '0)) begin
          state_d    = RELEASE;
          oversize_d = 1'b1;
        end
      end
      RELEASE: begin
        if (rd && out_last) state_d = IDLE_GATE;
      end
      default: state_d = IDLE_GATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      pkt_q      <= '0;
      tready_q   <= 1'b0;
      valid_q    <= 1'b0;
      oversize_q <= 1'b0;
      state_q    <= IDLE_GATE;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      pkt_q      <= pkt_d;
      tready_q   <= cnt_d < CW'(DEPTH);
      valid_q    <= valid_d;
      oversize_q <= oversize_d;
      state_q    <= state_d;
    end
  end

  axis_sdp_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr),
    .wr_addr_i (wptr_q),
    .wr_data_i (wr_entry),
    .rd_en_i   (load),
    .rd_addr_i (rptr_q),
    .rd_data_o (rd_entry)
  );

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = rd_entry[OFF_DATA +: DATA_W];
  assign m_axis_tkeep  = rd_entry[OFF_KEEP +: KW];
  assign m_axis_tstrb  = rd_entry[OFF_STRB +: KW];
  assign m_axis_tlast  = out_last;
  assign data_count    = cnt_q;
  assign pkt_count     = pkt_q;
  assign oversize      = oversize_q;

  if (SWAP_ID != 0) begin : g_swap
    assign m_axis_tid   = rd_entry[0 +: ID_W];
    assign m_axis_tdest = rd_entry[DEST_W +: DEST_W];
  end else begin : g_pass
    assign m_axis_tid   = rd_entry[DEST_W +: ID_W];
    assign m_axis_tdest = rd_entry[0 +: DEST_W];
  end

endmodule
